regfile_wb_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback and a long-latency execution unit (mul/div, late loads). The pipeline always owns the port when it writes. Long-latency results are buffered and written back in idle slots. Fairness is guaranteed by a starvation-triggered pipeline stall. A per-register pending scoreboard tells decode which source registers are waiting on a buffered result. It sits between writeback, the long-latency unit and the 32x32 register file (write-first, x0 hardwired zero, asynchronous reads).

---
 rtl/regfile_wb_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : regfile_wb_arbiter
// Purpose  : Arbitrates the single register-file write port between the
//            in-order pipeline writeback (A) and a buffered long-latency
//            result stream (B). A always wins when it writes; B results wait
//            in a FIFO and drain in idle slots. A starvation counter forces a
//            one-cycle pipeline stall so the buffer head is always written.
//            A pending scoreboard flags source registers still waiting on a
//            buffered result.
// Ports    : clk, rst_n                 - clock, async active-low reset
//            a_we, a_wa, a_wd           - pipeline writeback
//            b_valid, b_ready, b_wa,
//            b_wd                       - long-latency result handshake
//            iss_valid, iss_wa          - long-latency issue (sets pending)
//            ra1, ra2, haz1, haz2       - decode hazard lookup
//            stall_a                    - pipeline must not write this cycle
//            rf_we, rf_wa, rf_wd        - register file write port
// Revision : 1.0 - initial release
// ============================================================================
module regfile_wb_arbiter #(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        a_we,
    input  logic [4:0]  a_wa,
    input  logic [31:0] a_wd,
    input  logic        b_valid,
    output logic        b_ready,
    input  logic [4:0]  b_wa,
    input  logic [31:0] b_wd,
    input  logic        iss_valid,
    input  logic [4:0]  iss_wa,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic        haz1,
    output logic        haz2,
    output logic        stall_a,
    output logic        rf_we,
    output logic [4:0]  rf_wa,
    output logic [31:0] rf_wd
);

    localparam int AW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    localparam logic [AW:0]   c_count_full = (AW + 1)'(DEPTH);
    localparam logic [SW-1:0] c_starve_max = SW'(STARVE_LIMIT);
    localparam logic [SW-1:0] c_starve_pre = SW'(STARVE_LIMIT - 1);

    // Result buffer storage and control
    logic [4:0]    r_buf_wa [DEPTH];
    logic [31:0]   r_buf_wd [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;

    // Scoreboard, starvation tracking
    logic [31:1]   r_pending;
    logic [SW-1:0] r_starve;
    logic          r_stall;

    logic          w_a_busy;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [4:0]    w_head_wa;
    logic [31:0]   w_head_wd;
    logic [31:0]   w_pend_vec;
    logic [SW-1:0] w_starve_next;
    logic          w_stall_next;

    // ------------------------------------------------------------------------
    // Slot classification and port mux. A write to x0 is a no-op for the
    // register file, so it leaves the slot free for the buffer head.
    // ------------------------------------------------------------------------
    assign w_a_busy  = a_we && (a_wa != 5'd0);
    assign w_empty   = (r_count == '0);
    assign w_head_wa = r_buf_wa[r_rd_ptr];
    assign w_head_wd = r_buf_wd[r_rd_ptr];

    // b_ready comes straight from the registered count; no path from b_valid.
    assign b_ready = (r_count != c_count_full);

    // Results to x0 complete the handshake but never enter the buffer.
    assign w_push = b_valid && b_ready && (b_wa != 5'd0);
    assign w_pop  = !w_a_busy && !w_empty;

    assign rf_we = w_a_busy || !w_empty;
    assign rf_wa = w_a_busy ? a_wa : w_head_wa;
    assign rf_wd = w_a_busy ? a_wd : w_head_wd;

    // ------------------------------------------------------------------------
    // FIFO. Pointers wrap naturally because DEPTH is a power of two. A push
    // while full cannot happen since w_push already requires b_ready.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_buf_wa[r_wr_ptr] <= b_wa;
            r_buf_wd[r_wr_ptr] <= b_wd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Pending scoreboard. Each bit is set by an issue and cleared when the
    // matching head entry pops; a same-cycle issue to that register wins so a
    // newer in-flight op is never lost. Bit 0 does not exist (x0 constant).
    // ------------------------------------------------------------------------
    generate
        for (genvar gi = 1; gi < 32; gi++) begin : g_pending
            logic w_set;
            logic w_clr;

            assign w_set = iss_valid && (iss_wa == 5'(gi));
            assign w_clr = w_pop && (w_head_wa == 5'(gi));

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pending[gi] <= 1'b0;
                end else begin
                    r_pending[gi] <= w_set || (r_pending[gi] && !w_clr);
                end
            end
        end
    endgenerate

    assign w_pend_vec = {r_pending, 1'b0};
    assign haz1       = w_pend_vec[ra1];
    assign haz2       = w_pend_vec[ra2];

    // ------------------------------------------------------------------------
    // Starvation counter: counts consecutive cycles the head is blocked by A.
    // The stall pulse is raised only on the edge the counter first reaches
    // the limit, so it lasts exactly one cycle; the head then pops in that
    // stalled cycle, which also returns the counter to zero.
    // ------------------------------------------------------------------------
    always_comb begin
        w_starve_next = r_starve;
        w_stall_next  = 1'b0;
        if (w_empty || w_pop) begin
            w_starve_next = '0;
        end else if (w_a_busy && (r_starve != c_starve_max)) begin
            w_starve_next = r_starve + 1'b1;
            w_stall_next  = (r_starve == c_starve_pre);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
            r_stall  <= 1'b0;
        end else begin
            r_starve <= w_starve_next;
            r_stall  <= w_stall_next;
        end
    end

    assign stall_a = r_stall;

    // ------------------------------------------------------------------------
    // Upstream contract checks (simulation only effect).
    // ------------------------------------------------------------------------
    a_no_write_during_stall : assert property (
        @(posedge clk) disable iff (!rst_n) !(r_stall && w_a_busy)
    );

    a_no_waw_on_pending : assert property (
        @(posedge clk) disable iff (!rst_n) !(w_a_busy && w_pend_vec[a_wa])
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_wb_arbiter
// Purpose  : Self-checking bench for regfile_wb_arbiter. A transaction-level
//            reference (result queue, pending bit array, starvation count)
//            predicts every output each cycle; directed steps exercise the
//            named scenarios, then a randomized phase runs against the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_we, b_valid, iss_valid;
    logic [4:0]  a_wa, b_wa, iss_wa, ra1, ra2;
    logic [31:0] a_wd, b_wd;
    logic        b_ready, haz1, haz2, stall_a, rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wd;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [4:0]  mq_wa [$];
    logic [31:0] mq_wd [$];
    logic [31:0] m_pend;
    int          m_starve;
    bit          m_stall;

    regfile_wb_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd),
        .b_valid(b_valid), .b_ready(b_ready), .b_wa(b_wa), .b_wd(b_wd),
        .iss_valid(iss_valid), .iss_wa(iss_wa),
        .ra1(ra1), .ra2(ra2), .haz1(haz1), .haz2(haz2),
        .stall_a(stall_a),
        .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic idle_in();
        a_we = 1'b0; a_wa = '0; a_wd = '0;
        b_valid = 1'b0; b_wa = '0; b_wd = '0;
        iss_valid = 1'b0; iss_wa = '0;
        ra1 = '0; ra2 = '0;
    endtask

    task automatic model_reset();
        mq_wa.delete();
        mq_wd.delete();
        m_pend   = '0;
        m_starve = 0;
        m_stall  = 1'b0;
    endtask

    // Compare all outputs against the reference for the current inputs.
    task automatic check_outputs();
        bit abusy;
        #1;
        abusy = a_we && (a_wa != 5'd0);
        chk("b_ready", 32'(b_ready), 32'(mq_wa.size() < DEPTH));
        if (abusy) begin
            chk("rf_we_a", 32'(rf_we), 32'd1);
            chk("rf_wa_a", 32'(rf_wa), 32'(a_wa));
            chk("rf_wd_a", rf_wd, a_wd);
        end else if (mq_wa.size() > 0) begin
            chk("rf_we_b", 32'(rf_we), 32'd1);
            chk("rf_wa_b", 32'(rf_wa), 32'(mq_wa[0]));
            chk("rf_wd_b", rf_wd, mq_wd[0]);
        end else begin
            chk("rf_we_idle", 32'(rf_we), 32'd0);
        end
        chk("haz1", 32'(haz1), 32'(m_pend[ra1]));
        chk("haz2", 32'(haz2), 32'(m_pend[ra2]));
        chk("stall_a", 32'(stall_a), 32'(m_stall));
    endtask

    // Advance the reference by one clock edge using the rules of the block.
    task automatic model_update();
        int n;
        bit abusy, pop, push, new_stall;
        n     = mq_wa.size();
        abusy = a_we && (a_wa != 5'd0);
        pop   = !abusy && (n > 0);
        push  = b_valid && (n < DEPTH) && (b_wa != 5'd0);
        if (pop) begin
            m_pend[mq_wa[0]] = 1'b0;
            void'(mq_wa.pop_front());
            void'(mq_wd.pop_front());
        end
        if (push) begin
            mq_wa.push_back(b_wa);
            mq_wd.push_back(b_wd);
        end
        if (iss_valid && iss_wa != 5'd0) m_pend[iss_wa] = 1'b1;
        new_stall = 1'b0;
        if (n == 0 || pop) begin
            m_starve = 0;
        end else if (abusy && m_starve < LIMIT) begin
            m_starve++;
            if (m_starve == LIMIT) new_stall = 1'b1;
        end
        m_stall = new_stall;
    endtask

    task automatic clock();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        check_outputs();
        clock();
    endtask

    initial begin
        idle_in();
        model_reset();

        // ---------------- Reset state ----------------
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_b_ready", 32'(b_ready), 32'd1);
        chk("rst_stall", 32'(stall_a), 32'd0);
        chk("rst_rf_we", 32'(rf_we), 32'd0);
        chk("rst_haz1", 32'(haz1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // ---------------- Issue x5, buffered result, hazard clears ----------
        idle_in(); iss_valid = 1'b1; iss_wa = 5'd5; ra1 = 5'd5;
        step();
        idle_in(); ra1 = 5'd5; b_valid = 1'b1; b_wa = 5'd5; b_wd = 32'hDEADBEEF;
        check_outputs();
        chk("haz1_x5_set", 32'(haz1), 32'd1);
        clock();
        idle_in(); ra1 = 5'd5;
        check_outputs();
        chk("x5_rf_we", 32'(rf_we), 32'd1);
        chk("x5_rf_wa", 32'(rf_wa), 32'd5);
        chk("x5_rf_wd", rf_wd, 32'hDEADBEEF);
        clock();
        idle_in(); ra1 = 5'd5;
        check_outputs();
        chk("haz1_x5_clr", 32'(haz1), 32'd0);
        clock();

        // ---------------- Starvation with continuous A writes ---------------
        idle_in(); a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h3333_0000;
        b_valid = 1'b1; b_wa = 5'd10; b_wd = 32'hA0A0_0010;
        step();
        a_wd = 32'h3333_0001; b_wa = 5'd11; b_wd = 32'hA0A0_0011;
        step();
        b_valid = 1'b0;
        for (int k = 0; k < LIMIT - 1; k++) begin
            a_wd = 32'h3333_0100 + 32'(k);
            check_outputs();
            chk("starve_full", 32'(b_ready), 32'd0);
            chk("starve_nostall", 32'(stall_a), 32'd0);
            clock();
        end
        a_we = 1'b0; a_wa = 5'd0;
        check_outputs();
        chk("starve_stall", 32'(stall_a), 32'd1);
        chk("starve_b_wa", 32'(rf_wa), 32'd10);
        clock();
        a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h3333_0200;
        check_outputs();
        chk("starve_stall_off", 32'(stall_a), 32'd0);
        chk("starve_count1", 32'(b_ready), 32'd1);
        clock();
        idle_in();
        step();
        step();

        // ---------------- Result to x0 is dropped; A to x0 is idle ----------
        idle_in(); b_valid = 1'b1; b_wa = 5'd0; b_wd = 32'h0BAD_0BAD;
        check_outputs();
        chk("x0_handshake", 32'(b_ready), 32'd1);
        clock();
        idle_in();
        check_outputs();
        chk("x0_no_write", 32'(rf_we), 32'd0);
        clock();
        idle_in(); b_valid = 1'b1; b_wa = 5'd12; b_wd = 32'h1212_1212;
        step();
        idle_in(); a_we = 1'b1; a_wa = 5'd0; a_wd = 32'hFFFF_FFFF;
        check_outputs();
        chk("a_x0_drain_we", 32'(rf_we), 32'd1);
        chk("a_x0_drain_wa", 32'(rf_wa), 32'd12);
        clock();

        // ---------------- Same-cycle issue and pop of x7 --------------------
        idle_in(); iss_valid = 1'b1; iss_wa = 5'd7;
        step();
        idle_in(); b_valid = 1'b1; b_wa = 5'd7; b_wd = 32'h7777_7777; ra1 = 5'd7;
        step();
        idle_in(); iss_valid = 1'b1; iss_wa = 5'd7; ra1 = 5'd7;
        check_outputs();
        chk("x7_pop_wa", 32'(rf_wa), 32'd7);
        clock();
        idle_in(); ra1 = 5'd7; ra2 = 5'd7;
        check_outputs();
        chk("x7_set_wins", 32'(haz1), 32'd1);
        clock();

        // ---------------- Push+pop at count 1, pointer wrap -----------------
        idle_in(); a_we = 1'b1; a_wa = 5'd3; a_wd = 32'h3;
        b_valid = 1'b1; b_wa = 5'd20; b_wd = 32'h2000_0000;
        step();
        for (int i = 0; i < 2 * DEPTH + 2; i++) begin
            idle_in(); b_valid = 1'b1; b_wa = 5'(21 + i); b_wd = 32'h2000_0001 + 32'(i);
            check_outputs();
            chk("pp_ready", 32'(b_ready), 32'd1);
            chk("pp_order", rf_wd, 32'h2000_0000 + 32'(i));
            clock();
        end
        idle_in();
        step();
        step();

        // ---------------- Reset mid-stream ----------------------------------
        idle_in(); a_we = 1'b1; a_wa = 5'd3; iss_valid = 1'b1; iss_wa = 5'd9;
        b_valid = 1'b1; b_wa = 5'd9; b_wd = 32'h9999_9999;
        step();
        b_wa = 5'd14; b_wd = 32'h1414_1414; iss_wa = 5'd14;
        step();
        idle_in(); ra1 = 5'd9; ra2 = 5'd14;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("mrst_b_ready", 32'(b_ready), 32'd1);
        chk("mrst_haz1", 32'(haz1), 32'd0);
        chk("mrst_haz2", 32'(haz2), 32'd0);
        chk("mrst_stall", 32'(stall_a), 32'd0);
        chk("mrst_rf_we", 32'(rf_we), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check_outputs();
            chk("mrst_dropped", 32'(rf_we), 32'd0);
            clock();
        end

        // ---------------- Randomized traffic --------------------------------
        for (int i = 0; i < 600; i++) begin
            idle_in();
            a_we  = ($urandom_range(0, 3) != 0);
            a_wa  = 5'($urandom_range(0, 31));
            a_wd  = $urandom;
            if (m_pend[a_wa]) a_wa = 5'd0;
            if (m_stall) a_we = 1'b0;
            b_valid   = ($urandom_range(0, 1) != 0);
            b_wa      = 5'($urandom_range(0, 31));
            b_wd      = $urandom;
            iss_valid = ($urandom_range(0, 5) == 0);
            iss_wa    = 5'($urandom_range(0, 31));
            ra1       = 5'($urandom_range(0, 31));
            ra2       = 5'($urandom_range(0, 31));
            step();
        end

        idle_in();
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
